// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: input synchronizer, run-length glitch filter, phase
// decoder with an illegal-jump detector, and a wrapping position counter.
module quadrature_decoder #(
  parameter int NBITS_COUNT   = 4,
  parameter int FILTER_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_in,
  input  logic                   b_in,
  input  logic                   enable,
  input  logic                   clear_err,
  output logic                   step,
  output logic                   count_up,
  output logic [NBITS_COUNT-1:0] Count,
  output logic                   error
);

  localparam logic [3:0] RUN_TARGET = 4'(FILTER_CYCLES);

  logic [1:0] a_ff;
  logic [1:0] b_ff;
  logic [1:0] phase;
  logic [1:0] filt;
  logic [1:0] cand;
  logic [3:0] run;
  logic       primed;

  logic       accept;
  logic [3:0] run_nx;
  logic [1:0] cand_nx;
  logic       dir_up;
  logic       dir_dn;
  logic       err_set;

  // Up sequence 00 -> 10 -> 11 -> 01 -> 00 (A leads B).
  function automatic logic [1:0] next_up(input logic [1:0] p);
    logic [1:0] n;
    case (p)
      2'b00:   n = 2'b10;
      2'b10:   n = 2'b11;
      2'b11:   n = 2'b01;
      2'b01:   n = 2'b00;
      default: n = 2'b00;
    endcase
    return n;
  endfunction

  assign phase = {a_ff[1], b_ff[1]};

  // Filter run tracking; before priming every value, including filt itself, must earn acceptance.
  always_comb begin
    accept  = 1'b0;
    run_nx  = 4'd0;
    cand_nx = cand;
    if (primed && (phase == filt)) begin
      run_nx = 4'd0;
    end else if ((run != 4'd0) && (phase == cand)) begin
      if ((run + 4'd1) >= RUN_TARGET) begin
        accept = 1'b1;
      end else begin
        run_nx = run + 4'd1;
      end
    end else begin
      cand_nx = phase;
      if (RUN_TARGET <= 4'd1) begin
        accept = 1'b1;
      end else begin
        run_nx = 4'd1;
      end
    end
  end

  always_comb begin
    dir_up  = (phase == next_up(filt));
    dir_dn  = (filt == next_up(phase));
    err_set = accept && primed && enable && !dir_up && !dir_dn;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_ff     <= 2'b00;
      b_ff     <= 2'b00;
      filt     <= 2'b00;
      cand     <= 2'b00;
      run      <= 4'd0;
      primed   <= 1'b0;
      step     <= 1'b0;
      count_up <= 1'b1;
      Count    <= '0;
      error    <= 1'b0;
    end else begin
      a_ff <= {a_ff[0], a_in};
      b_ff <= {b_ff[0], b_in};
      run  <= run_nx;
      cand <= cand_nx;
      step <= 1'b0;
      if (accept) begin
        filt   <= phase;
        primed <= 1'b1;
        // The priming load and disabled periods only move filt.
        if (primed && enable) begin
          if (dir_up) begin
            step     <= 1'b1;
            count_up <= 1'b1;
            Count    <= Count + NBITS_COUNT'(1);
          end else if (dir_dn) begin
            step     <= 1'b1;
            count_up <= 1'b0;
            Count    <= Count - NBITS_COUNT'(1);
          end
        end
      end
      if (err_set) begin
        error <= 1'b1;
      end else if (clear_err) begin
        error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed bench for quadrature_decoder: expected steps are queued when a phase
// change is driven and checked (direction, count, edge) when step pulses.
module tb_quadrature_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_in = 1'b0;
  logic       b_in = 1'b0;
  logic       enable = 1'b1;
  logic       clear_err = 1'b0;
  logic       step;
  logic       count_up;
  logic [3:0] Count;
  logic       error;

  typedef struct {
    logic       up;
    logic [3:0] cnt;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         steps_seen = 0;
  int         steps_pushed = 0;
  logic [3:0] exp_count = 4'd0;
  logic       exp_up = 1'b1;

  quadrature_decoder #(.NBITS_COUNT(4), .FILTER_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .enable(enable),
    .clear_err(clear_err), .step(step), .count_up(count_up), .Count(Count),
    .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive a phase just after an edge; if a valid step is expected, queue it
  // with its arrival edge (capture at the next edge, then 3 more edges).
  task automatic drive(input logic a, input logic b, input bit expect_step, input logic up);
    @(posedge clk);
    #1;
    a_in = a;
    b_in = b;
    if (expect_step) begin
      exp_count = up ? exp_count + 4'd1 : exp_count - 4'd1;
      exp_up = up;
      sb.push_back('{up: up, cnt: exp_count, cyc: cyc + 4});
      steps_pushed++;
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    hold(2);
    reset = 1'b0;
    exp_count = 4'd0;
    exp_up = 1'b1;
  endtask

  always @(negedge clk) begin
    if (step) begin
      steps_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_step", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("step_dir", int'(count_up), int'(e.up));
        chk("step_count", int'(Count), int'(e.cnt));
        chk("step_edge", cyc, e.cyc);
      end
    end
  end

  initial begin
    // 1. reset and prime at phase 00
    hold(2);
    reset = 1'b0;
    hold(8);
    chk("rst_count", int'(Count), 0);
    chk("rst_step", int'(step), 0);
    chk("rst_count_up", int'(count_up), 1);
    chk("rst_error", int'(error), 0);

    // 2. forward rotation
    drive(1'b1, 1'b0, 1'b1, 1'b1); hold(6);
    drive(1'b1, 1'b1, 1'b1, 1'b1); hold(6);
    drive(1'b0, 1'b1, 1'b1, 1'b1); hold(6);
    drive(1'b0, 1'b0, 1'b1, 1'b1); hold(6);
    chk("fwd_count", int'(Count), 4);
    chk("fwd_count_up", int'(count_up), 1);

    // 3. reverse step from 0 wraps to 15
    do_reset();
    hold(8);
    chk("rst2_count", int'(Count), 0);
    drive(1'b0, 1'b1, 1'b1, 1'b0); hold(6);
    chk("wrap_count", int'(Count), 15);
    chk("wrap_count_up", int'(count_up), 0);

    // 4. glitch rejection, then a held pulse
    drive(1'b0, 1'b0, 1'b1, 1'b1); hold(6);
    chk("back_to_zero", int'(Count), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0); hold(6);
    chk("glitch_count", int'(Count), 0);
    drive(1'b1, 1'b0, 1'b1, 1'b1); hold(6);
    chk("held_pulse_count", int'(Count), 1);

    // 5. illegal jump, clear, and clear colliding with a new jump
    drive(1'b0, 1'b0, 1'b1, 1'b0); hold(6);
    chk("pre_jump_error", int'(error), 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0); hold(6);
    chk("jump_error", int'(error), 1);
    chk("jump_count", int'(Count), 0);
    chk("jump_count_up", int'(count_up), 0);
    clear_err = 1'b1; hold(1); clear_err = 1'b0;
    chk("cleared_error", int'(error), 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    hold(3);
    clear_err = 1'b1; hold(1); clear_err = 1'b0;
    chk("set_beats_clear", int'(error), 1);
    hold(2);
    clear_err = 1'b1; hold(1); clear_err = 1'b0;
    chk("cleared_again", int'(error), 0);

    // 6. disabled rotation, re-enable, reset during a filter run
    enable = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0); hold(6);
    drive(1'b1, 1'b1, 1'b0, 1'b0); hold(6);
    drive(1'b0, 1'b1, 1'b0, 1'b0); hold(6);
    drive(1'b0, 1'b0, 1'b0, 1'b0); hold(6);
    chk("disabled_count", int'(Count), 0);
    enable = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b1); hold(6);
    chk("reenable_count", int'(Count), 1);
    chk("reenable_error", int'(error), 0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    hold(2);
    reset = 1'b1; hold(1); reset = 1'b0;
    exp_count = 4'd0;
    chk("midrun_rst_count", int'(Count), 0);
    chk("midrun_rst_step", int'(step), 0);
    hold(10);
    chk("after_rst_count", int'(Count), 0);
    chk("after_rst_count_up", int'(count_up), 1);

    chk("pending_steps", sb.size(), 0);
    chk("total_steps", steps_seen, steps_pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
# quadrature_decoder

Decodes a two-phase quadrature signal pair (A/B) into single-cycle step pulses, a direction flag and a wrapping position count. The `contador` up/down counter consumes the same `count_up` semantics; this block is the producing end, turning an external encoder into count-and-direction information. It sits between asynchronous encoder pins and the counting/display logic. It includes a synchronizer, a glitch filter, a phase decoder and an invalid-transition detector.

## Interface
- `NBITS_COUNT`, 4: width of `Count`.
- `FILTER_CYCLES`, 2: consecutive identical synchronized samples required before a new phase is accepted; legal range 1–15.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `a_in`  in  1  encoder phase A, asynchronous.
- `b_in`  in  1  encoder phase B, asynchronous.
- `enable`  in  1  1 = report steps and errors; 0 = track phase silently.
- `clear_err`  in  1  clears sticky `error`.
- `step`  out  1  one-cycle pulse per accepted valid phase step.
- `count_up`  out  1  direction of the most recent valid step (1 = up).
- `Count`  out  NBITS_COUNT  position; +1 per up step, −1 per down step.
- `error`  out  1  sticky flag for an illegal two-bit phase jump.

## Operation
- **Synchronizer.** Two flops per input. The phase vector is `{A,B}`.
- **Filter.**
  - Holds the accepted phase `filt` (2 bits) and a run counter.
  - A run is consecutive edges at which the synchronized vector presents the same value different from `filt`.
  - When the run reaches `FILTER_CYCLES`, `filt` loads that value.
  - Any change of the synchronized value, or a return to `filt`, clears the run.
- **Priming.**
  - After reset the block is unprimed.
  - The first value held for `FILTER_CYCLES` consecutive samples (including 00) loads `filt` and sets primed.
  - This first load produces no step, no error and no `Count` change.
- **Decode on each `filt` load while primed.** The up sequence is 00→10→11→01→00 (A leads B).
  - Next in the sequence: up step.
  - Previous in the sequence: down step.
  - Both bits changed: invalid.
- **enable=1.**
  - Up step: `step`=1, `count_up`=1, `Count`+1.
  - Down step: `step`=1, `count_up`=0, `Count`−1.
  - Invalid: `error`←1; no `step`, `Count` and `count_up` unchanged.
- **enable=0.** `filt` still tracks the phase; no `step`, no `Count`/`count_up`/`error` change. Steps missed while disabled are never replayed.
- **Arithmetic.** `Count` wraps modulo 2^NBITS_COUNT: max+1→0, 0−1→max.
- **Error handling.** `error` is sticky until `clear_err`=1. If a set and `clear_err` occur at the same edge, the set wins.
- **Reset values.** `reset`=1 at an edge sets:
  - `Count`=0, `step`=0, `count_up`=1, `error`=0;
  - sync flops=0, `filt`=00, run=0, unprimed.
  - Reset overrides everything, including a run in progress.

## Timing
- **Latency.** An input change first captured by the synchronizer at edge n gives a `filt` update, `step` assertion and `Count` update at edge n+FILTER_CYCLES+1.
  - With the default, that is 3 edges after capture.
- **step.** High for exactly one cycle per valid step.
- **Minimum interval.** Two steps are at least FILTER_CYCLES cycles apart.
- **Glitch rejection.** Glitches shorter than FILTER_CYCLES cycles after synchronization produce no `filt` change.
- **Priming time.** Priming completes no later than edge r+FILTER_CYCLES+2, where r is the first edge with `reset`=0. Phase changes before priming are absorbed into the initial `filt`.
- **Registered outputs.** `count_up`, `Count` and `error` update on the same edge as `step`. All outputs are registered.

## Test plan
1. **Reset and prime.** Hold `reset`=1 for 2 cycles with inputs 00, then wait 8 cycles. Expect `Count`=0, `step`=0, `count_up`=1, `error`=0.
2. **Forward rotation.** From the primed state, drive 00→10→11→01→00 with each phase held 6 cycles and `enable`=1. Expect 4 `step` pulses, each 3 edges after capture; `Count` goes 1,2,3,4; `count_up`=1 throughout.
3. **Reverse wrap.** From `Count`=0 at phase 00, drive 01. Expect one `step`, `Count`=15, `count_up`=0.
4. **Glitch.** At phase 00, pulse `a_in` high for 1 cycle. Expect no `step` and `Count` unchanged; the same pulse held for 4 cycles then produces exactly one up step.
5. **Illegal jump.**
   - Drive 00→11 and hold. Expect `error`=1, no `step`, `Count` unchanged.
   - Pulse `clear_err`. Expect `error`=0.
   - Force a new jump on the same edge as `clear_err`. Expect `error`=1.
6. **Enable and reset mid-run.**
   - With `enable`=0, run 4 forward steps. Expect `Count` unchanged.
   - Re-enable and apply 1 step. Expect `Count`+1, with no catch-up.
   - Assert `reset` mid filter run. Expect `Count`=0 and no `step` from that run.
